muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Replaces single-cycle combinational multiply/divide with an iterative shift-add multiplier and a restoring divider, sequenced by an FSM.
- Sits beside the main ALU in EX; the pipeline holds EX while `busy` is high and writes back on `resp_valid`.
- Resolves RISC-V divide-by-zero and signed-overflow cases without iterating.

Parameters:
- N, 32, operand/result width; iteration count = N.
- TAGW, 5, width of destination-register tag carried through.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; equals (state==IDLE).
- req_op  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_a  in  N  rs1 operand.
- req_b  in  N  rs2 operand.
- req_rd  in  TAGW  destination tag.
- flush  in  1  abort the current operation (branch/exception kill).
- busy  out  1  operation in flight; high in CALC, FIX and DONE.
- resp_valid  out  1  single-cycle result pulse.
- resp_result  out  N  result; held until the next resp_valid.
- resp_rd  out  TAGW  tag of the result.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - resp_valid=0, resp_result=0, resp_rd=0, busy=0, req_ready=1.
  - Reset mid-operation discards all work; no response is produced.
- Accept: req_valid && req_ready && !flush at a rising edge. Latch op, a, b, rd, sign flags and magnitudes.
- Signedness:
  - a is signed for MULH, MULHSU, DIV and REM.
  - b is signed for MULH, DIV and REM.
  - Magnitude = two's-complement absolute value; |−2^(N−1)| is treated as unsigned 2^(N−1).
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE→DONE on accept of a special case:
    - DIV/DIVU with b==0: result all-ones.
    - REM/REMU with b==0: result = a.
    - DIV with a==0x80..0 and b==all-ones: result = a.
    - REM with the same operands: result = 0.
  - IDLE→CALC on any other accept; counter cleared.
  - CALC: one iteration per cycle, counter increments; after N cycles in CALC → FIX.
    - Multiply: 2N-bit accumulator; add multiplicand if multiplier LSB=1, then shift.
    - Divide: shift remainder left one bit, trial-subtract divisor, set quotient bit if non-negative, else restore.
  - FIX: apply sign and select result.
    - Product negated if sign_a^sign_b.
    - Quotient negated if sign_a^sign_b.
    - Remainder takes sign_a.
    - MUL returns the low N bits; MULH/MULHSU/MULHU return the high N bits.
  - FIX→DONE.
  - DONE: resp_valid=1 for exactly one cycle with resp_result and resp_rd; → IDLE.
- Latency (accept edge → edge at which resp_valid is first sampled high):
  - Normal ops: N+2 cycles (34 for N=32).
  - Special cases: 1 cycle.
- Throughput: one op in flight. A new accept is possible in the cycle after DONE.
- flush:
  - In CALC or FIX: next state IDLE; no resp_valid; resp_result/resp_rd unchanged.
  - In DONE: resp_valid still pulses; flush has no effect.
  - In IDLE: blocks accept (flush wins over req_valid).
- req_* inputs are ignored while busy; the latched operands are used.
- resp_result is registered; no combinational path from req_* to resp_*.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (−3), rd=5 → resp_valid exactly 34 cycles after accept; result 0xFFFFFFEB; resp_rd=5; busy high throughout; req_ready low until the cycle after DONE.
- MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU a=100, b=7 → 14. REMU same operands → 2.
- Special cases, each with 1-cycle latency:
  - DIVU a=123, b=0 → 0xFFFFFFFF.
  - REM a=123, b=0 → 123.
  - DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- flush pulsed on the 10th CALC cycle of DIV 100/7 → no resp_valid; req_ready=1 next cycle; back-to-back MUL 3*4 then returns 12.
- rst_n asserted asynchronously mid-CALC (between clock edges) → all outputs immediately 0, req_ready=1; no stale resp_valid after release. Simultaneous flush+req_valid in IDLE → request not accepted.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
// Ports: clk, rst_n (async active-low) | req_valid/req_ready/req_op/req_a/req_b/req_rd request |
//        flush abort | busy | resp_valid/resp_result/resp_rd registered response
module muldiv_sequencer #(
  parameter int N = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [N-1:0]    req_a,
  input  logic [N-1:0]    req_b,
  input  logic [TAGW-1:0] req_rd,
  input  logic            flush,
  output logic            busy,
  output logic            resp_valid,
  output logic [N-1:0]    resp_result,
  output logic [TAGW-1:0] resp_rd
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0] op_q;
  logic neg_q, sa_q;
  logic [N-1:0] opnd_q;
  logic [2*N-1:0] acc_q;
  logic [TAGW-1:0] rd_q;
  logic accept, sa, sb, div_zero, ovf, special;
  logic [N-1:0] mag_a, mag_b, spec_res, quo, rmd, fix_res;
  logic [N:0] sum, trial;
  logic [2*N-1:0] step, prod;
  assign req_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign resp_valid = state_q == DONE;
  always_comb begin
    accept = req_valid & req_ready & ~flush;
    sa = req_a[N-1] & (req_op == 3'b001 | req_op == 3'b010 | req_op == 3'b100 | req_op == 3'b110);
    sb = req_b[N-1] & (req_op == 3'b001 | req_op == 3'b100 | req_op == 3'b110);
    mag_a = sa ? -req_a : req_a;
    mag_b = sb ? -req_b : req_b;
    div_zero = req_op[2] & (req_b == '0);
    ovf = (req_op == 3'b100 | req_op == 3'b110) & (req_a == {1'b1, {(N-1){1'b0}}}) & (&req_b);
    special = div_zero | ovf;
    spec_res = div_zero ? (req_op[1] ? req_a : '1) : (req_op[1] ? '0 : req_a);
    // acc holds {high partial product, remaining multiplier} or {remainder, dividend/quotient}
    sum = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    trial = acc_q[2*N-1:N-1] - {1'b0, opnd_q};
    step = op_q[2] ? (trial[N] ? {acc_q[2*N-2:0], 1'b0} : {trial[N-1:0], acc_q[N-2:0], 1'b1})
                   : {sum, acc_q[N-1:1]};
    prod = neg_q ? -acc_q : acc_q;
    quo = neg_q ? -acc_q[N-1:0] : acc_q[N-1:0];
    rmd = sa_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
    fix_res = op_q[2] ? (op_q[1] ? rmd : quo) : (op_q[1:0] == 2'b00 ? prod[N-1:0] : prod[2*N-1:N]);
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = accept ? (special ? DONE : CALC) : IDLE;
      CALC: state_d = flush ? IDLE : (cnt_q == CW'(N-1) ? FIX : CALC);
      FIX:  state_d = flush ? IDLE : DONE;
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      resp_result <= '0;
      resp_rd <= '0;
    end else begin
      state_q <= state_d;
      if (accept) cnt_q <= '0;
      else if (state_q == CALC) cnt_q <= cnt_q + 1'b1;
      if (accept && special) begin
        resp_result <= spec_res;
        resp_rd <= req_rd;
      end else if (state_q == FIX && !flush) begin
        resp_result <= fix_res;
        resp_rd <= rd_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= req_op;
      neg_q <= sa ^ sb;
      sa_q <= sa;
      opnd_q <= req_op[2] ? mag_b : mag_a;
      acc_q <= {{N{1'b0}}, req_op[2] ? mag_a : mag_b};
      rd_q <= req_rd;
    end else if (state_q == CALC) acc_q <= step;
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vector bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic clk = 0, rst_n = 0, req_valid = 0, flush = 0;
  logic [2:0] req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [4:0] req_rd = '0;
  logic req_ready, busy, resp_valid;
  logic [31:0] resp_result;
  logic [4:0] resp_rd;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [2:0] op;
    logic [31:0] a, b;
    logic [4:0] rd;
    logic [31:0] exp;
    int lat;
  } vec_t;
  vec_t v[16];
  muldiv_sequencer #(.N(32), .TAGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
    .busy(busy), .resp_valid(resp_valid), .resp_result(resp_result), .resp_rd(resp_rd)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Issues one op, keeps garbage requests asserted while busy, checks latency/result/tag/pulse.
  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int cyc, busy_low, ready_high;
    @(negedge clk);
    req_valid = 1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    @(posedge clk);
    #1 req_op = 3'($urandom); req_a = $urandom; req_b = $urandom; req_rd = 5'($urandom);
    cyc = 0; busy_low = 0; ready_high = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (!busy) busy_low++;
      if (req_ready) ready_high++;
      if (resp_valid) break;
    end
    req_valid = 0;
    chk({name, " latency"}, 32'(cyc), 32'(lat));
    chk({name, " result"}, resp_result, exp);
    chk({name, " rd"}, 32'(resp_rd), 32'(rd));
    chk({name, " busy_low_cycles"}, 32'(busy_low), 0);
    chk({name, " ready_high_cycles"}, 32'(ready_high), 0);
    @(negedge clk);
    chk({name, " pulse_end"}, 32'(resp_valid), 0);
    chk({name, " ready_after"}, 32'(req_ready), 1);
    chk({name, " result_held"}, resp_result, exp);
  endtask
  initial begin
    int hits;
    v[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34};
    v[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 34};
    v[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, 34};
    v[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 34};
    v[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 34};
    v[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 34};
    v[6]  = '{3'b101, 32'd100,      32'd7,        5'd7,  32'd14,       34};
    v[7]  = '{3'b111, 32'd100,      32'd7,        5'd8,  32'd2,        34};
    v[8]  = '{3'b101, 32'd123,      32'd0,        5'd9,  32'hFFFFFFFF, 1};
    v[9]  = '{3'b110, 32'd123,      32'd0,        5'd10, 32'd123,      1};
    v[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1};
    v[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 1};
    v[12] = '{3'b111, 32'd5,        32'd0,        5'd13, 32'd5,        1};
    v[13] = '{3'b100, 32'h80000000, 32'd1,        5'd14, 32'h80000000, 34};
    v[14] = '{3'b100, 32'hFFFFFF9C, 32'd7,        5'd15, 32'hFFFFFFF2, 34};
    v[15] = '{3'b110, 32'hFFFFFF9C, 32'd7,        5'd16, 32'hFFFFFFFE, 34};
    #12;
    chk("reset resp_valid", 32'(resp_valid), 0);
    chk("reset resp_result", resp_result, 0);
    chk("reset resp_rd", 32'(resp_rd), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset req_ready", 32'(req_ready), 1);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 16; i++) run($sformatf("vec%0d", i), v[i].op, v[i].a, v[i].b, v[i].rd, v[i].exp, v[i].lat);
    // flush on the 10th CALC cycle of DIVU 100/7
    @(negedge clk);
    req_valid = 1; req_op = 3'b101; req_a = 32'd100; req_b = 32'd7; req_rd = 5'd3;
    @(posedge clk);
    #1 req_valid = 0;
    hits = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (resp_valid) hits++;
    end
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush resp_valid", 32'(resp_valid | (hits != 0)), 0);
    chk("flush req_ready", 32'(req_ready), 1);
    chk("flush busy", 32'(busy), 0);
    chk("flush result_unchanged", resp_result, 32'hFFFFFFFE);
    chk("flush rd_unchanged", 32'(resp_rd), 16);
    run("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd17, 32'd12, 34);
    // async reset mid-CALC
    @(negedge clk);
    req_valid = 1; req_op = 3'b101; req_a = 32'd100; req_b = 32'd7; req_rd = 5'd20;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst resp_valid", 32'(resp_valid), 0);
    chk("arst resp_result", resp_result, 0);
    chk("arst resp_rd", 32'(resp_rd), 0);
    chk("arst busy", 32'(busy), 0);
    chk("arst req_ready", 32'(req_ready), 1);
    @(negedge clk);
    rst_n = 1;
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid) hits++;
    end
    chk("arst no_stale_resp", 32'(hits), 0);
    // flush and req_valid together in IDLE
    @(negedge clk);
    req_valid = 1; flush = 1; req_op = 3'b101; req_a = 32'd1; req_b = 32'd0; req_rd = 5'd7;
    hits = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid || !req_ready) hits++;
    end
    req_valid = 0; flush = 0;
    chk("flush_blocks_accept", 32'(hits), 0);
    chk("flush_blocks_rd", 32'(resp_rd), 0);
    run("after_block", 3'b011, 32'h00010000, 32'h00010000, 5'd31, 32'd1, 34);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
